// File: rtl/demux_frame_router.sv
// Bit-serial frame parser feeding a 1-to-4 demux: decodes a 2-bit channel onto s1/s0 and streams the payload onto in_o.
// Optional even-parity check is built when DEMUX_ROUTER_PARITY_EN is defined; otherwise parity_err is tied low.
module demux_frame_router #(
    parameter int PAYLOAD_BITS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic       rx_bit,
    output logic       in_o,
    output logic       s1,
    output logic       s0,
    output logic       busy,
    output logic       frame_done,
    output logic       frame_err,
    output logic       parity_err,
    output logic [2:0] dbg_state_o
);

    localparam int CW = $clog2(PAYLOAD_BITS + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(PAYLOAD_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_PARITY  = 3'd3,
        ST_STOP    = 3'd4
    } state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          addr_ph_q;
    logic          a1_q;
    logic          in_q;
    logic          s1_q;
    logic          s0_q;
    logic          busy_q;
    logic          done_q;
    logic          ferr_q;
`ifdef DEMUX_ROUTER_PARITY_EN
    logic          par_q;
    logic          perr_q;
`endif

    // Handshake: rx_bit is consumed only on cycles with rx_valid=1; all state holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_ph_q <= 1'b0;
            a1_q      <= 1'b0;
            in_q      <= 1'b0;
            s1_q      <= 1'b0;
            s0_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef DEMUX_ROUTER_PARITY_EN
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            ferr_q <= 1'b0;
`ifdef DEMUX_ROUTER_PARITY_EN
            perr_q <= 1'b0;
`endif
            if (rx_valid) begin
                case (state_q)
                    ST_IDLE: begin
                        in_q <= 1'b0;
                        if (rx_bit) begin
                            state_q   <= ST_ADDR;
                            busy_q    <= 1'b1;
                            addr_ph_q <= 1'b0;
                        end
                    end
                    ST_ADDR: begin
                        if (!addr_ph_q) begin
                            a1_q      <= rx_bit;
                            addr_ph_q <= 1'b1;
                        end else begin
                            // Both selects load together so the demux never sees a transient channel.
                            s1_q      <= a1_q;
                            s0_q      <= rx_bit;
                            addr_ph_q <= 1'b0;
                            cnt_q     <= '0;
                            state_q   <= ST_PAYLOAD;
`ifdef DEMUX_ROUTER_PARITY_EN
                            par_q     <= a1_q ^ rx_bit;
`endif
                        end
                    end
                    ST_PAYLOAD: begin
                        in_q  <= rx_bit;
                        cnt_q <= cnt_q + CW'(1);
`ifdef DEMUX_ROUTER_PARITY_EN
                        par_q <= par_q ^ rx_bit;
                        if (cnt_q == LAST_IDX) state_q <= ST_PARITY;
`else
                        if (cnt_q == LAST_IDX) state_q <= ST_STOP;
`endif
                    end
`ifdef DEMUX_ROUTER_PARITY_EN
                    ST_PARITY: begin
                        perr_q  <= par_q ^ rx_bit;
                        state_q <= ST_STOP;
                    end
`endif
                    ST_STOP: begin
                        in_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= ~rx_bit;
                        ferr_q  <= rx_bit;
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        in_q    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign in_o        = in_q;
    assign s1          = s1_q;
    assign s0          = s0_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;
    assign frame_err   = ferr_q;
    assign dbg_state_o = state_q;
`ifdef DEMUX_ROUTER_PARITY_EN
    assign parity_err  = perr_q;
`else
    assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_demux_frame_router.sv
// Directed + randomized bench for demux_frame_router against a frame-level reference model.
// Adapts the frame format to the DEMUX_ROUTER_PARITY_EN build.
module tb_demux_frame_router;

    localparam int PB = 8;

    logic       clk;
    logic       rst_n;
    logic       rx_valid;
    logic       rx_bit;
    logic       in_o;
    logic       s1;
    logic       s0;
    logic       busy;
    logic       frame_done;
    logic       frame_err;
    logic       parity_err;
    logic [2:0] dbg_state;

    int vectors;
    int miscompares;

    // reference model: what the outputs must read after the latest clock edge
    logic exp_in, exp_s1, exp_s0, exp_busy, exp_done, exp_ferr, exp_perr;

    demux_frame_router #(.PAYLOAD_BITS(PB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_valid   (rx_valid),
        .rx_bit     (rx_bit),
        .in_o       (in_o),
        .s1         (s1),
        .s0         (s0),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .dbg_state_o(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string where);
        chk({where, ".in_o"},       in_o,       exp_in);
        chk({where, ".s1"},         s1,         exp_s1);
        chk({where, ".s0"},         s0,         exp_s0);
        chk({where, ".busy"},       busy,       exp_busy);
        chk({where, ".frame_done"}, frame_done, exp_done);
        chk({where, ".frame_err"},  frame_err,  exp_ferr);
        chk({where, ".parity_err"}, parity_err, exp_perr);
    endtask

    task automatic clear_pulses();
        exp_done = 1'b0;
        exp_ferr = 1'b0;
        exp_perr = 1'b0;
    endtask

    task automatic clear_all();
        exp_in = 1'b0; exp_s1 = 1'b0; exp_s0 = 1'b0; exp_busy = 1'b0;
        clear_pulses();
    endtask

    // one clock: drive at negedge, edge samples, return at the next negedge
    task automatic one_cycle(input logic v, input logic b);
        rx_valid = v;
        rx_bit   = b;
        @(posedge clk);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // random idle gap (state must hold, pulses must drop), then one strobe
    task automatic send_bit(input logic b, input int maxgap);
        int gap;
        gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
        for (int g = 0; g < gap; g++) begin
            one_cycle(1'b0, 1'($urandom_range(0, 1)));
            clear_pulses();
            check_all("gap");
        end
        one_cycle(1'b1, b);
        clear_pulses();
    endtask

    task automatic send_frame(input logic [1:0] addr, input logic [15:0] data,
                              input logic bad_par, input logic stop_bit, input int maxgap);
        int   ones;
        logic p;
        send_bit(1'b1, maxgap);
        exp_busy = 1'b1; exp_in = 1'b0;
        check_all("start");
        send_bit(addr[1], maxgap);
        check_all("a1");
        send_bit(addr[0], maxgap);
        exp_s1 = addr[1]; exp_s0 = addr[0];
        check_all("a0");
        for (int i = PB - 1; i >= 0; i--) begin
            send_bit(data[i], maxgap);
            exp_in = data[i];
            check_all("payload");
        end
`ifdef DEMUX_ROUTER_PARITY_EN
        ones = 0;
        if (addr[1]) ones++;
        if (addr[0]) ones++;
        for (int i = 0; i < PB; i++) if (data[i]) ones++;
        p = 1'((ones % 2) ^ int'(bad_par));
        send_bit(p, maxgap);
        exp_perr = bad_par;
        check_all("parity");
`else
        ones = 0;
        p    = bad_par;
`endif
        send_bit(stop_bit, maxgap);
        exp_in = 1'b0; exp_busy = 1'b0;
        exp_done = ~stop_bit; exp_ferr = stop_bit;
        check_all("stop");
    endtask

    task automatic idle_check();
        one_cycle(1'b0, 1'b0);
        clear_pulses();
        check_all("post");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rx_valid    = 1'b0;
        rx_bit      = 1'b0;
        rst_n       = 1'b0;
        clear_all();
        repeat (3) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // idle zeros are ignored
        for (int k = 0; k < 5; k++) begin
            send_bit(1'b0, 0);
            check_all("idle0");
        end

        // channel 2, 0xA5, good parity, good stop
        send_frame(2'd2, 16'h00A5, 1'b0, 1'b0, 0);
        idle_check();
`ifdef DEMUX_ROUTER_PARITY_EN
        // same frame with corrupted parity; done still fires
        send_frame(2'd2, 16'h00A5, 1'b1, 1'b0, 0);
        idle_check();
`endif
        // channel 3, 0xFF, stop sent as 1, then an immediate start
        send_frame(2'd3, 16'h00FF, 1'b0, 1'b1, 0);
        send_frame(2'd1, 16'($urandom_range(0, 255)), 1'b0, 1'b0, 0);
        idle_check();

        // reset mid-frame after the 4th payload bit
        send_bit(1'b1, 0); exp_busy = 1'b1; check_all("r.start");
        send_bit(1'b1, 0); check_all("r.a1");
        send_bit(1'b0, 0); exp_s1 = 1'b1; exp_s0 = 1'b0; check_all("r.a0");
        for (int i = 0; i < 4; i++) begin
            send_bit(1'b1, 0);
            exp_in = 1'b1;
            check_all("r.payload");
        end
        #2 rst_n = 1'b0;
        #1 clear_all();
        check_all("async_rst");
        @(negedge clk);
        check_all("rst_hold");
        rst_n = 1'b1;
        idle_check();
        send_frame(2'd0, 16'h003C, 1'b0, 1'b0, 0);

        // 12-bit style frame with random gaps, channel 3, 0xA5
        send_frame(2'd3, 16'h00A5, 1'b0, 1'b0, 5);
        idle_check();

        // randomized frames
        for (int f = 0; f < 25; f++) begin
            send_frame(2'($urandom_range(0, 3)), 16'($urandom_range(0, 255)),
                       ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                       int'($urandom_range(0, 5)));
            if ($urandom_range(0, 1) == 1) idle_check();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // hard time bound so the bench never hangs
    initial begin
        #2000000;
        $display("FAIL timeout vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

endmodule
